// File: rtl/lsu_mem_if.sv
// MEM-stage load/store unit driving a word-organised synchronous SRAM.
// Steers byte lanes, extends loads, and splits word-crossing accesses into two transactions.
module lsu_mem_if #(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              memwrite,
  input  logic              memtoreg,
  input  logic [1:0]        lwhb,
  input  logic [1:0]        swhb,
  input  logic              lunsigned,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_WAIT, RESP
  } state_t;

  state_t state, state_nxt;

  logic              accept;
  logic [2:0]        req_size;
  logic [2:0]        size_q;
  logic [1:0]        off_q;
  logic [MEM_AW-1:0] lo_idx_q;
  logic [31:0]       wdata_q;
  logic              uns_q;
  logic [31:0]       lo_data_q;
  logic              split;
  logic [3:0]        size_mask;
  logic [7:0]        st_mask;
  logic [63:0]       st_wide;
  logic [63:0]       st_data;
  logic [31:0]       ld_lo;
  logic [31:0]       ld_bytes;
  logic [31:0]       load_result;
  logic              unused_addr_hi;

  // Address bits above the SRAM span alias onto it.
  assign unused_addr_hi = ^addr[31:MEM_AW+2];

  assign req_ready = (state == IDLE) & ~reset;
  assign accept    = req_valid & req_ready & (memwrite | memtoreg);
  assign split     = (4'(off_q) + 4'(size_q)) > 4'd4;

  // Access size in bytes; 0 marks a no-op store.
  always_comb begin
    req_size = 3'd4;
    if (memwrite) begin
      case (swhb)
        2'b01:   req_size = 3'd4;
        2'b10:   req_size = 3'd2;
        2'b11:   req_size = 3'd1;
        default: req_size = 3'd0;
      endcase
    end else begin
      case (lwhb)
        2'b01:   req_size = 3'd2;
        2'b10:   req_size = 3'd1;
        default: req_size = 3'd4;
      endcase
    end
  end

  always_comb begin
    case (size_q)
      3'd4:    size_mask = 4'hF;
      3'd2:    size_mask = 4'h3;
      3'd1:    size_mask = 4'h1;
      default: size_mask = 4'h0;
    endcase
    st_mask = {4'b0, size_mask} << off_q;
    st_wide = {32'b0, wdata_q} << {off_q, 3'b000};
    st_data = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      st_data[i*8 +: 8] = st_mask[i] ? st_wide[i*8 +: 8] : 8'h00;
    end
  end

  // In RD_WAIT mem_rdata holds the last word read: the high word if split, else the only word.
  always_comb begin
    ld_lo    = split ? lo_data_q : mem_rdata;
    ld_bytes = 32'({mem_rdata, ld_lo} >> {off_q, 3'b000});
    case (size_q)
      3'd2:    load_result = {{16{~uns_q & ld_bytes[15]}}, ld_bytes[15:0]};
      3'd1:    load_result = {{24{~uns_q & ld_bytes[7]}}, ld_bytes[7:0]};
      default: load_result = ld_bytes;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rdata     <= '0;
      size_q    <= '0;
      off_q     <= '0;
      lo_idx_q  <= '0;
      wdata_q   <= '0;
      uns_q     <= 1'b0;
      lo_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        size_q   <= req_size;
        off_q    <= addr[1:0];
        lo_idx_q <= addr[MEM_AW+1:2];
        wdata_q  <= wdata;
        uns_q    <= lunsigned;
      end
      if (state == RD_HI) lo_data_q <= mem_rdata;
      if (state == RD_WAIT) rdata <= load_result;
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_en     = 1'b0;
    mem_we     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (memwrite) state_nxt = (req_size == 3'd0) ? RESP : WR_LO;
          else          state_nxt = RD_LO;
        end
      end
      WR_LO: begin
        mem_en     = 1'b1;
        mem_we     = st_mask[3:0];
        mem_addr   = lo_idx_q;
        mem_wdata  = st_data[31:0];
        resp_valid = ~split;
        state_nxt  = split ? WR_HI : IDLE;
      end
      WR_HI: begin
        mem_en     = 1'b1;
        mem_we     = st_mask[7:4];
        mem_addr   = lo_idx_q + 1'b1;
        mem_wdata  = st_data[63:32];
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      RD_LO: begin
        mem_en    = 1'b1;
        mem_addr  = lo_idx_q;
        state_nxt = split ? RD_HI : RD_WAIT;
      end
      RD_HI: begin
        mem_en    = 1'b1;
        mem_addr  = lo_idx_q + 1'b1;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
